// File: rtl/sub16se_pkg.sv
// Shared constants and the approximate-subtract reference function for sub16se_pipe.
// approx_sub is the single definition of the arithmetic used by the datapath.
package sub16se_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int LSB_DEF   = 4;
    localparam int HI_W      = WIDTH_DEF - LSB_DEF + 1;

    // Low LSB bits pass a through; b's low field only feeds the borrow hint into the high field.
    function automatic logic [WIDTH_DEF:0] approx_sub(
        input logic [WIDTH_DEF-1:0] a,
        input logic [WIDTH_DEF-1:0] b
    );
        logic            hint_s;
        logic [HI_W-1:0] d_hi_s;
        hint_s = ~a[LSB_DEF-1] & b[LSB_DEF-1];
        d_hi_s = {a[WIDTH_DEF-1], a[WIDTH_DEF-1:LSB_DEF]}
               - {b[WIDTH_DEF-1], b[WIDTH_DEF-1:LSB_DEF]}
               - {{(HI_W-1){1'b0}}, hint_s};
        return {d_hi_s, a[LSB_DEF-1:0]};
    endfunction

endpackage

// File: rtl/sub16se_pipe_slice.sv
// One valid/ready register stage; ready is combinational from the downstream ready.
module pipe_slice #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    import sub16se_pkg::*;

    logic          valid_r;
    logic [DW-1:0] data_r;
    logic          advance_s;

    assign advance_s = !valid_r || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Stage register: loads whenever the slot is empty or being drained this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {DW{1'b0}};
        end else if (advance_s) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/sub16se_pipe.sv
// Two-stage pipelined approximate signed subtractor: S1 splits the operands and
// forms the borrow hint, S2 registers the high-field subtraction.
module sub16se_pipe
    import sub16se_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LSB   = LSB_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_d
);
    localparam int HW   = WIDTH - LSB;
    localparam int S1_W = 2 * HW + 1 + LSB;

    logic              hint_s;
    logic [S1_W-1:0]   s1_in_s;
    logic [S1_W-1:0]   s1_q_s;
    logic              s1_ready_s;
    logic              s1_valid_s;
    logic              s2_ready_s;
    logic [HW-1:0]     a_hi_s;
    logic [HW-1:0]     b_hi_s;
    logic              hint_q_s;
    logic [LSB-1:0]    a_lo_s;
    logic [WIDTH-1:0]  a_rec_s;
    logic [WIDTH-1:0]  b_rec_s;
    logic [WIDTH:0]    d_s;

    assign hint_s   = ~in_a[LSB-1] & in_b[LSB-1];
    assign s1_in_s  = {in_a[WIDTH-1:LSB], in_b[WIDTH-1:LSB], hint_s, in_a[LSB-1:0]};
    assign in_ready = s1_ready_s & ~rst;

    pipe_slice #(.DW(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s1_ready_s),
        .in_data   (s1_in_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_q_s)
    );

    assign a_hi_s   = s1_q_s[S1_W-1 -: HW];
    assign b_hi_s   = s1_q_s[S1_W-1-HW -: HW];
    assign hint_q_s = s1_q_s[LSB];
    assign a_lo_s   = s1_q_s[LSB-1:0];
    assign a_rec_s  = {a_hi_s, a_lo_s};

    // Rebuild a subtrahend whose low field reproduces the stored borrow bit; a set borrow means a's top low bit is clear.
    always_comb begin
        b_rec_s        = {b_hi_s, {LSB{1'b0}}};
        b_rec_s[LSB-1] = hint_q_s;
    end

    assign d_s = approx_sub(a_rec_s, b_rec_s);

    pipe_slice #(.DW(WIDTH + 1)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (d_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_d)
    );

endmodule
